// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel loader: default geometry, FSM state
// encoding, colour channel layout and the gamma curve used by the optional
// LUT stage (enabled with LED_GAMMA_EN).
package led_panel_pkg;

  localparam int DEF_COLOR_BITS = 8;
  localparam int DEF_ROWS_LINES = 4;
  localparam int DEF_COLS_LINES = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD      = 2'b01,
    SWAP_WAIT = 2'b10
  } load_state_t;

  // Channel index inside a packed {blue, green, red} pixel; red in the LSBs.
  localparam int RED_CH   = 0;
  localparam int GREEN_CH = 1;
  localparam int BLUE_CH  = 2;

  // LSB position of a channel field for a given channel width.
  function automatic int chan_lsb(input int ch, input int bits);
    return ch * bits;
  endfunction

  // Gamma 2.0 curve: out = x*x / 2**bits, so full scale maps just below full scale.
  function automatic longint gamma_value(input longint x, input int bits);
    return (x * x) >>> bits;
  endfunction

endpackage

// File: rtl/led_gamma_lut.sv
// Registered gamma ROM for one colour channel. Only used when LED_GAMMA_EN
// is defined; contents are computed from led_panel_pkg::gamma_value.
module led_gamma_lut
  import led_panel_pkg::*;
#(
  parameter int COLOR_BITS = DEF_COLOR_BITS
) (
  input  logic                  CLK_50,
  input  logic [COLOR_BITS-1:0] addr,
  output logic [COLOR_BITS-1:0] data
);

  localparam int DEPTH = 2 ** COLOR_BITS;

  logic [COLOR_BITS-1:0] table_rom [DEPTH];

  // Constant table contents, one entry per input code.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
      assign table_rom[gi] = COLOR_BITS'(gamma_value(longint'(gi), COLOR_BITS));
    end
  endgenerate

  // Registered read so the table maps onto block ROM.
  always_ff @(posedge CLK_50) begin
    data <= table_rom[addr];
  end

endmodule

// File: rtl/led_frame_loader.sv
// Raster pixel stream to LED framebuffer loader. Writes each accepted pixel
// into the back buffer, then waits for v_sync (with the write pipeline
// drained) before toggling backbuffer. Define LED_GAMMA_EN to insert a
// per-channel gamma LUT stage (write latency 2 instead of 1).
module led_frame_loader
  import led_panel_pkg::*;
#(
  parameter int COLOR_BITS         = DEF_COLOR_BITS,
  parameter int DISPLAY_ROWS_LINES = DEF_ROWS_LINES,
  parameter int DISPLAY_COLS_LINES = DEF_COLS_LINES,
  localparam int AW = DISPLAY_ROWS_LINES + DISPLAY_COLS_LINES + 1,
  localparam int DW = 3 * COLOR_BITS
) (
  input  logic          CLK_50,
  input  logic          RST,
  input  logic [DW-1:0] pix_data,
  input  logic          pix_valid,
  input  logic          pix_sof,
  output logic          pix_ready,
  output logic [AW-1:0] memAddrOut,
  output logic [DW-1:0] memDataOut,
  output logic          memWrite,
  input  logic          v_sync,
  output logic          backbuffer,
  output logic          frame_swapped,
  output logic          sof_error,
  output logic [7:0]    err_count
);

  // Raster index n maps straight onto {half, row, col}, so the counter is the address.
  localparam logic [AW-1:0] LAST_PIX = {AW{1'b1}};

  load_state_t   state;
  logic [AW-1:0] cnt;
  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          pipe_busy;

  assign accept = pix_valid && pix_ready;

  // Decide whether the accepted pixel is written and where (SOF always lands at 0).
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = cnt;
    if (accept) begin
      case (state)
        IDLE: begin
          if (pix_sof) begin
            wr_en   = 1'b1;
            wr_addr = '0;
          end
        end
        LOAD: begin
          wr_en = 1'b1;
          if (pix_sof) wr_addr = '0;
        end
        default: ;
      endcase
    end
  end

`ifdef LED_GAMMA_EN
  logic          stage_wr;
  logic [AW-1:0] stage_addr;
  logic [DW-1:0] gamma_data;

  generate
    for (genvar gi = RED_CH; gi <= BLUE_CH; gi++) begin : g_lut
      led_gamma_lut #(
        .COLOR_BITS(COLOR_BITS)
      ) u_lut (
        .CLK_50(CLK_50),
        .addr  (pix_data[chan_lsb(gi, COLOR_BITS) +: COLOR_BITS]),
        .data  (gamma_data[chan_lsb(gi, COLOR_BITS) +: COLOR_BITS])
      );
    end
  endgenerate

  // Delay strobe and address one stage to line up with the registered LUT output.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      stage_wr   <= 1'b0;
      stage_addr <= '0;
    end else begin
      stage_wr   <= wr_en;
      stage_addr <= wr_addr;
    end
  end

  // Output write register fed from the gamma-corrected data.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      memWrite   <= 1'b0;
      memAddrOut <= '0;
      memDataOut <= '0;
    end else begin
      memWrite <= stage_wr;
      if (stage_wr) begin
        memAddrOut <= stage_addr;
        memDataOut <= gamma_data;
      end
    end
  end

  assign pipe_busy = stage_wr || memWrite;
`else
  // Output write register; address/data hold their last written values between strobes.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      memWrite   <= 1'b0;
      memAddrOut <= '0;
      memDataOut <= '0;
    end else begin
      memWrite <= wr_en;
      if (wr_en) begin
        memAddrOut <= wr_addr;
        memDataOut <= pix_data;
      end
    end
  end

  assign pipe_busy = memWrite;
`endif

  // Frame sequencing FSM with registered ready, swap and error outputs.
  always_ff @(posedge CLK_50) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      pix_ready     <= 1'b0;
      backbuffer    <= 1'b0;
      frame_swapped <= 1'b0;
      sof_error     <= 1'b0;
      err_count     <= 8'd0;
    end else begin
      frame_swapped <= 1'b0;
      sof_error     <= 1'b0;
      case (state)
        IDLE: begin
          pix_ready <= 1'b1;
          if (accept && pix_sof) begin
            cnt   <= AW'(1);
            state <= LOAD;
          end
        end
        LOAD: begin
          pix_ready <= 1'b1;
          if (accept) begin
            if (pix_sof) begin
              // Early SOF restarts the frame; the SOF pixel itself is pixel 0.
              cnt       <= AW'(1);
              sof_error <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (cnt == LAST_PIX) begin
              cnt       <= '0;
              state     <= SWAP_WAIT;
              pix_ready <= 1'b0;
            end else begin
              cnt <= cnt + AW'(1);
            end
          end
        end
        SWAP_WAIT: begin
          pix_ready <= 1'b0;
          // Swap only once every write of this frame has left the pipeline.
          if (v_sync && !pipe_busy) begin
            backbuffer    <= ~backbuffer;
            frame_swapped <= 1'b1;
            state         <= IDLE;
            pix_ready     <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          pix_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed testbench for led_frame_loader (default geometry 2048 pixels).
// Follows LED_GAMMA_EN for write latency and expected write data.
module tb_led_frame_loader;

  localparam int CB   = 8;
  localparam int AW   = 11;
  localparam int DW   = 24;
  localparam int NPIX = 2048;
`ifdef LED_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK_50 = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] pix_data = '0;
  logic          pix_valid = 1'b0;
  logic          pix_sof = 1'b0;
  logic          v_sync = 1'b0;
  logic          pix_ready;
  logic [AW-1:0] memAddrOut;
  logic [DW-1:0] memDataOut;
  logic          memWrite;
  logic          backbuffer;
  logic          frame_swapped;
  logic          sof_error;
  logic [7:0]    err_count;

  int checks = 0;
  int errors = 0;
  int writes = 0;
  int swaps  = 0;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t q[$];

  always #10 CLK_50 = ~CLK_50;

  led_frame_loader dut (
    .CLK_50       (CLK_50),
    .RST          (RST),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .pix_ready    (pix_ready),
    .memAddrOut   (memAddrOut),
    .memDataOut   (memDataOut),
    .memWrite     (memWrite),
    .v_sync       (v_sync),
    .backbuffer   (backbuffer),
    .frame_swapped(frame_swapped),
    .sof_error    (sof_error),
    .err_count    (err_count)
  );

  // Expected write data: raw pixel, or x*x>>8 per channel with gamma enabled
  // (e.g. 0x00FF00 -> 0x00FE00).
  function automatic logic [DW-1:0] expect_data(input logic [DW-1:0] d);
`ifdef LED_GAMMA_EN
    logic [DW-1:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      int x;
      x = int'(d[c*CB +: CB]);
      r[c*CB +: CB] = CB'((x * x) >> CB);
    end
    return r;
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, queue the write they should cause, compare the
  // write that is due now (LAT cycles after its acceptance).
  task automatic cycle(input logic valid, input logic sof, input logic [DW-1:0] data,
                       input logic vs, input logic exp_wr, input logic [AW-1:0] exp_addr);
    wr_t e;
    pix_valid = valid;
    pix_sof   = sof;
    pix_data  = data;
    v_sync    = vs;
    e.wr   = exp_wr;
    e.addr = exp_addr;
    e.data = expect_data(data);
    q.push_back(e);
    @(posedge CLK_50);
    #1;
    if (memWrite) writes++;
    if (frame_swapped) swaps++;
    if (q.size() >= LAT) begin
      e = q.pop_front();
      check("memWrite", 32'(memWrite), 32'(e.wr));
      if (e.wr) begin
        check("memAddrOut", 32'(memAddrOut), 32'(e.addr));
        check("memDataOut", 32'(memDataOut), 32'(e.data));
      end
    end
  endtask

  // Reset for one edge with a pixel offered, check reset values, then release.
  task automatic do_reset();
    RST       = 1'b1;
    pix_valid = 1'b1;
    pix_sof   = 1'b0;
    v_sync    = 1'b0;
    @(posedge CLK_50);
    #1;
    q.delete();
    for (int i = 0; i < LAT - 1; i++) q.push_back('0);
    check("rst_pix_ready", 32'(pix_ready), 32'd0);
    check("rst_memWrite", 32'(memWrite), 32'd0);
    check("rst_memAddrOut", 32'(memAddrOut), 32'd0);
    check("rst_memDataOut", 32'(memDataOut), 32'd0);
    check("rst_backbuffer", 32'(backbuffer), 32'd0);
    check("rst_frame_swapped", 32'(frame_swapped), 32'd0);
    check("rst_sof_error", 32'(sof_error), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    RST = 1'b0;
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("post_rst_pix_ready", 32'(pix_ready), 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Leading garbage in IDLE: ready stays high, nothing written.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 24'hABC000 + DW'(i), 1'b0, 1'b0, '0);
      check("garbage_ready", 32'(pix_ready), 32'd1);
    end
    check("garbage_writes", 32'(writes), 32'd0);

    // Full frame, data = index, with a v_sync pulse in LOAD that must be ignored.
    for (int n = 0; n < NPIX; n++) begin
      cycle(1'b1, n == 0, DW'(n), n == 500, 1'b1, AW'(n));
      if (n == 500) check("load_backbuffer", 32'(backbuffer), 32'd0);
    end
    check("frame1_ready_low", 32'(pix_ready), 32'd0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 24'h5A5A5A, 1'b0, 1'b0, '0);
    check("frame1_writes", 32'(writes), 32'(NPIX));
    check("wait_backbuffer", 32'(backbuffer), 32'd0);
    check("wait_swaps", 32'(swaps), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("swap1_backbuffer", 32'(backbuffer), 32'd1);
    check("swap1_pulse", 32'(frame_swapped), 32'd1);
    check("swap1_ready", 32'(pix_ready), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("swap1_pulse_end", 32'(frame_swapped), 32'd0);
    check("swap1_count", 32'(swaps), 32'd1);

    // Early SOF at pixel 700: restart at 0, then 2047 more pixels finish the frame.
    writes = 0;
    for (int n = 0; n < 700; n++) cycle(1'b1, n == 0, 24'h100000 | DW'(n), 1'b0, 1'b1, AW'(n));
    check("pre_sof_error", 32'(sof_error), 32'd0);
    cycle(1'b1, 1'b1, 24'h200000, 1'b0, 1'b1, '0);
    check("sof_error_pulse", 32'(sof_error), 32'd1);
    check("err_count_1", 32'(err_count), 32'd1);
    for (int n = 1; n < NPIX; n++) begin
      cycle(1'b1, 1'b0, 24'h300000 | DW'(n), 1'b0, 1'b1, AW'(n));
      if (n == 1) check("sof_error_end", 32'(sof_error), 32'd0);
    end
    check("frame2_ready_low", 32'(pix_ready), 32'd0);
    // v_sync while writes are still in flight is not honoured.
    for (int i = 0; i < LAT; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
      check("busy_no_swap", 32'(backbuffer), 32'd1);
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("swap2_backbuffer", 32'(backbuffer), 32'd0);
    check("swap2_pulse", 32'(frame_swapped), 32'd1);
    check("frame2_writes", 32'(writes), 32'(700 + NPIX));
    check("err_count_hold", 32'(err_count), 32'd1);

    // pix_valid at 50%: exactly one contiguous write per accepted pixel.
    writes = 0;
    for (int n = 0; n < NPIX; n++) begin
      cycle(1'b0, 1'b0, 24'hDEAD00, 1'b0, 1'b0, '0);
      cycle(1'b1, n == 0, DW'(n * 3 + 7), 1'b0, 1'b1, AW'(n));
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("frame3_writes", 32'(writes), 32'(NPIX));
    check("frame3_ready_low", 32'(pix_ready), 32'd0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("swap3_backbuffer", 32'(backbuffer), 32'd1);

    // Reset in the middle of LOAD, then a fresh frame from address 0.
    for (int n = 0; n < 1000; n++) cycle(1'b1, n == 0, DW'(n), 1'b0, 1'b1, AW'(n));
    do_reset();
    for (int n = 0; n < 20; n++) cycle(1'b1, n == 0, 24'h000040 + DW'(n), 1'b0, 1'b1, AW'(n));
    check("fresh_backbuffer", 32'(backbuffer), 32'd0);
    check("fresh_ready", 32'(pix_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_loader.md
# led_frame_loader

Upstream feeder for the LED panel scan driver. Accepts a raster pixel stream with a valid/ready handshake and writes each pixel into the driver's back framebuffer through its write port. After a complete frame is written, it waits for the driver's `v_sync` pulse and then toggles `backbuffer`, so frames swap only on scan boundaries.

## Interface

Parameters:
- `COLOR_BITS`, 8 — bits per colour channel.
- `DISPLAY_ROWS_LINES`, 4 — row address bits per panel half.
- `DISPLAY_COLS_LINES`, 6 — column address bits.
- Derived: `AW = DISPLAY_ROWS_LINES + DISPLAY_COLS_LINES + 1`; `NPIX = 2**AW` (2048 by default).

Ports:
- `CLK_50` in 1 — clock.
- `RST` in 1 — reset, synchronous, active-high.
- `pix_data` in 3*COLOR_BITS — pixel data, packed as {blue, green, red}, red in the LSBs.
- `pix_valid` in 1 — `pix_data` is valid.
- `pix_sof` in 1 — marks the first pixel of a frame (pixel 0).
- `pix_ready` out 1 — block can accept a pixel.
- `memAddrOut` out AW — write address {half, row, col}.
- `memDataOut` out 3*COLOR_BITS — write data.
- `memWrite` out 1 — write strobe, one cycle per pixel.
- `v_sync` in 1 — one-cycle pulse from the scan driver at end of frame.
- `backbuffer` out 1 — selects which buffer is written.
- `frame_swapped` out 1 — one-cycle pulse when `backbuffer` toggles.
- `sof_error` out 1 — one-cycle pulse on an early SOF.
- `err_count` out 8 — count of early SOFs, saturating.

## Operation

- A pixel is accepted when `pix_valid && pix_ready`.
- Pixel index n is in raster order: y = n[AW-1:DISPLAY_COLS_LINES], x = n[DISPLAY_COLS_LINES-1:0].
- Address mapping: `memAddrOut` = {y[MSB] (half), y[DISPLAY_ROWS_LINES-1:0], x}. This equals n directly.
- State IDLE:
  - `pix_ready` = 1.
  - Accepted pixels without `pix_sof` are discarded (no write).
  - An accepted pixel with `pix_sof` is written at index 0; the pixel counter is set to 1; next state is LOAD.
- State LOAD:
  - `pix_ready` = 1.
  - Each accepted pixel is written at the counter value, then the counter increments.
  - When the pixel at index NPIX-1 is accepted, next state is SWAP_WAIT.
  - An accepted pixel with `pix_sof` in LOAD: `sof_error` pulses, `err_count` increments (holds at 255), the pixel is written at index 0, and the counter is set to 1. The state stays LOAD.
- State SWAP_WAIT:
  - `pix_ready` = 0.
  - `v_sync` is honoured only once the write pipeline is empty (no pending `memWrite`).
  - On an honoured `v_sync`: `backbuffer` toggles on the next edge, `frame_swapped` pulses in that same cycle, and next state is IDLE.
- `v_sync` in IDLE or LOAD is ignored. It is not remembered.
- Counter width is AW bits. It never wraps inside LOAD because the transition to SWAP_WAIT happens at NPIX-1.

## Timing

- Reset values:
  - `pix_ready` 0 (the cycle after reset releases, IDLE drives 1).
  - `memWrite` 0, `memAddrOut` 0, `memDataOut` 0.
  - `backbuffer` 0, `frame_swapped` 0, `sof_error` 0, `err_count` 0.
  - State IDLE, counter 0.
- Write latency: `memWrite`, `memAddrOut` and `memDataOut` are registered and assert 1 cycle after acceptance (2 cycles with `LED_GAMMA_EN`).
- Sustained throughput is 1 pixel per cycle in LOAD.
- `sof_error` asserts 1 cycle after acceptance of the offending pixel.
- Minimum SWAP_WAIT-to-toggle delay is pipeline depth + 1 cycles after the last acceptance.
- Reset during any state aborts immediately:
  - Pending writes are dropped.
  - `backbuffer` returns to 0.
  - The frame is restarted from IDLE.
- The scan memory may sample `memWrite` on a faster clock. Repeated writes of identical address/data within one `CLK_50` cycle are idempotent.

## Configuration

- `LED_GAMMA_EN` defined:
  - Each channel passes through a 2**COLOR_BITS-entry gamma LUT (same table for R, G, B) before the write register.
  - Adds one pipeline stage; write latency becomes 2.
- `LED_GAMMA_EN` undefined:
  - Data is written unmodified.
  - Write latency is 1.

## Structure

- Shared package `led_panel_pkg`:
  - Default `COLOR_BITS`, `DISPLAY_ROWS_LINES`, `DISPLAY_COLS_LINES`.
  - State encoding: IDLE=2'b00, LOAD=2'b01, SWAP_WAIT=2'b10.
  - Channel field offsets for red, green and blue.
- Sub-module `led_gamma_lut`:
  - Registered ROM, one instance per channel.
  - Instantiated only under `LED_GAMMA_EN`.

## Test plan

- **Reset, then 2048 pixels** with `pix_sof` on the first, data = index: expect 2048 writes with `memAddrOut` = `memDataOut[10:0]` = index, `backbuffer` 0 throughout, `pix_ready` 0 after the last pixel.
- **`v_sync` handling:** pulse `v_sync` during LOAD, then again 5 cycles into SWAP_WAIT. Expect the first pulse ignored; on the second, `backbuffer` goes 0→1 with a single `frame_swapped` pulse and the state returns to IDLE.
- **Early SOF:** assert `pix_sof` again at pixel 700. Expect a `sof_error` pulse, `err_count` = 1, the next write at address 0, and the frame then completing 2048 pixels later.
- **Leading garbage:** 10 pixels without SOF in IDLE. Expect `pix_ready` = 1 and no `memWrite`.
- **`pix_valid` toggled 50%** over a full frame. Expect exactly 2048 writes, contiguous addresses, no gaps or duplicates.
- **Reset mid-LOAD at pixel 1000.** Expect all outputs at reset values and a fresh SOF frame writing from address 0 into `backbuffer` 0.
- **With `LED_GAMMA_EN`:** `pix_data` 0x00FF00 gives `memDataOut` = {LUT[0x00], LUT[0xFF], LUT[0x00]} 2 cycles after acceptance.
